// File: rtl/pkt_arb_pkg.sv
// Shared types and constants for the packet round-robin arbiter.
package pkt_arb_pkg;

    localparam int NUM_CH      = 2;
    localparam int DEF_MAX_LEN = 128;
    localparam int DEF_DW      = 16;

    typedef enum logic [2:0] {IDLE, BUSY0, BUSY1, DROP0, DROP1} state_t;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic              err;
        logic [DEF_DW-1:0] data;
    } pkt_beat_t;

endpackage

// File: rtl/pkt_len_guard.sv
// Beat counter for the granted packet; flags the over-length beat and any stray sop.
module pkt_len_guard
    import pkt_arb_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    input  logic i_sop,
    input  logic i_eop,
    output logic o_first,
    output logic o_overlen,
    output logic o_stray
);

    logic [LEN_W-1:0] r_len_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_len_cnt <= '0;
        end else if (i_inc) begin
            r_len_cnt <= r_len_cnt + LEN_W'(1);
        end
    end

    assign o_first   = (r_len_cnt == '0);
    assign o_stray   = i_inc & i_sop & ~o_first;
    assign o_overlen = i_inc & ~i_eop & (r_len_cnt == LEN_W'(MAX_LEN - 1));

endmodule

// File: rtl/pkt_rr_arb.sv
// Packet-granular round-robin arbiter feeding one packet FIFO from two sources.
// Optional statistics counters are enabled with `define PKT_ARB_STAT_EN.
module pkt_rr_arb
    import pkt_arb_pkg::*;
#(
    parameter int DW      = 16,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ch0_vld,
    input  logic          ch0_sop,
    input  logic          ch0_eop,
    input  logic          ch0_err,
    input  logic [DW-1:0] ch0_din,
    output logic          ch0_rdy,
    input  logic          ch1_vld,
    input  logic          ch1_sop,
    input  logic          ch1_eop,
    input  logic          ch1_err,
    input  logic [DW-1:0] ch1_din,
    output logic          ch1_rdy,
    input  logic          dout_rdy,
    output logic          dout_vld,
    output logic          dout_sop,
    output logic          dout_eop,
    output logic          dout_err,
    output logic [DW-1:0] dout
`ifdef PKT_ARB_STAT_EN
    ,
    output logic [15:0]   pkt_cnt0,
    output logic [15:0]   pkt_cnt1,
    output logic [15:0]   err_cnt
`endif
);

    state_t            r_state;
    state_t            w_next;
    logic              r_last;
    logic [NUM_CH-1:0] w_req;
    logic              w_grant;
    logic              w_grant1;
    logic              w_sel1;
    logic              w_busy;
    logic              w_drop;
    logic              w_vld;
    logic              w_sop;
    logic              w_eop;
    logic              w_err;
    logic [DW-1:0]     w_din;
    logic              w_rdy;
    logic              w_acc;
    logic              w_clr;
    logic              w_inc;
    logic              w_first;
    logic              w_overlen;
    logic              w_stray;
    logic              w_force;

    assign w_req    = {ch1_vld & ch1_sop, ch0_vld & ch0_sop};
    assign w_grant  = |w_req;
    // On a tie the channel that did not win last time gets the grant.
    assign w_grant1 = w_req[1] & (~w_req[0] | ~r_last);

    assign w_sel1 = (r_state == BUSY1) || (r_state == DROP1);
    assign w_busy = (r_state == BUSY0) || (r_state == BUSY1);
    assign w_drop = (r_state == DROP0) || (r_state == DROP1);

    assign w_vld = w_sel1 ? ch1_vld : ch0_vld;
    assign w_sop = w_sel1 ? ch1_sop : ch0_sop;
    assign w_eop = w_sel1 ? ch1_eop : ch0_eop;
    assign w_err = w_sel1 ? ch1_err : ch0_err;
    assign w_din = w_sel1 ? ch1_din : ch0_din;
    assign w_rdy = w_sel1 ? ch1_rdy : ch0_rdy;

    assign w_acc   = w_vld & w_rdy & (w_busy | w_drop);
    assign w_clr   = (r_state == IDLE) & w_grant;
    assign w_inc   = w_busy & w_acc;
    assign w_force = w_stray | w_overlen;

    pkt_len_guard #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_len_guard (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_clr),
        .i_inc     (w_inc),
        .i_sop     (w_sop),
        .i_eop     (w_eop),
        .o_first   (w_first),
        .o_overlen (w_overlen),
        .o_stray   (w_stray)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_clr) begin
                r_last <= w_grant1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_next = w_grant1 ? BUSY1 : BUSY0;
                end
            end
            BUSY0, BUSY1: begin
                // A forced close on a beat that already carries eop leaves nothing to drop.
                if (w_inc) begin
                    if (w_eop) begin
                        w_next = IDLE;
                    end else if (w_force) begin
                        w_next = w_sel1 ? DROP1 : DROP0;
                    end
                end
            end
            DROP0, DROP1: begin
                if (w_acc && w_eop) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ch0_rdy = 1'b0;
        ch1_rdy = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    ch0_rdy = ~ch0_sop;
                    ch1_rdy = ~ch1_sop;
                end
                BUSY0:   ch0_rdy = dout_rdy;
                BUSY1:   ch1_rdy = dout_rdy;
                DROP0:   ch0_rdy = 1'b1;
                DROP1:   ch1_rdy = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            dout_err <= 1'b0;
            dout     <= '0;
        end else begin
            dout_vld <= w_inc;
            dout_sop <= w_inc & w_sop & w_first;
            dout_eop <= w_inc & (w_eop | w_force);
            dout_err <= w_inc & (w_err | w_force);
            if (w_inc) begin
                dout <= w_din;
            end
        end
    end

`ifdef PKT_ARB_STAT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
            err_cnt  <= '0;
        end else begin
            if (w_clr && !w_grant1) begin
                pkt_cnt0 <= sat_inc(pkt_cnt0);
            end
            if (w_clr && w_grant1) begin
                pkt_cnt1 <= sat_inc(pkt_cnt1);
            end
            if (w_inc && w_force) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pkt_rr_arb.sv
// Bench for pkt_rr_arb: per-packet reference transform, per-channel scoreboards, directed and random traffic.
module tb_pkt_rr_arb;
    import pkt_arb_pkg::*;

    localparam int DW      = 16;
    localparam int MAX_LEN = 128;
    localparam int LEN_W   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ch0_vld = 0, ch0_sop = 0, ch0_eop = 0, ch0_err = 0;
    logic [DW-1:0] ch0_din = '0;
    logic          ch0_rdy;
    logic          ch1_vld = 0, ch1_sop = 0, ch1_eop = 0, ch1_err = 0;
    logic [DW-1:0] ch1_din = '0;
    logic          ch1_rdy;
    logic          dout_rdy = 1'b1;
    logic          dout_vld, dout_sop, dout_eop, dout_err;
    logic [DW-1:0] dout;
`ifdef PKT_ARB_STAT_EN
    logic [15:0]   pkt_cnt0, pkt_cnt1, err_cnt;
`endif

    always #5 clk = ~clk;

    pkt_rr_arb #(.DW(DW), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .ch0_vld  (ch0_vld),
        .ch0_sop  (ch0_sop),
        .ch0_eop  (ch0_eop),
        .ch0_err  (ch0_err),
        .ch0_din  (ch0_din),
        .ch0_rdy  (ch0_rdy),
        .ch1_vld  (ch1_vld),
        .ch1_sop  (ch1_sop),
        .ch1_eop  (ch1_eop),
        .ch1_err  (ch1_err),
        .ch1_din  (ch1_din),
        .ch1_rdy  (ch1_rdy),
        .dout_rdy (dout_rdy),
        .dout_vld (dout_vld),
        .dout_sop (dout_sop),
        .dout_eop (dout_eop),
        .dout_err (dout_err),
        .dout     (dout)
`ifdef PKT_ARB_STAT_EN
        ,
        .pkt_cnt0 (pkt_cnt0),
        .pkt_cnt1 (pkt_cnt1),
        .err_cnt  (err_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    pkt_beat_t src_q[2][$];
    pkt_beat_t exp_q[2][$];
    int        sop_order[$];
    int        sop_cyc[$];
    int        eop_cyc[$];
    int        out_cnt[2];
    int        first_present[2];
    bit        idle_sop[2];
    int        cyc       = 0;
    int        cur_ch    = -1;
    int        gap_pct   = 0;
    int        rdy_mode  = 0;
    int        pat_idx   = 0;
    bit        pat[4];
    bit        mirror_on = 0;
    bit        in_pkt0   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: what the FIFO should receive for one source packet.
    task automatic add_pkt(input int ch, input int len, input int stray_at, input bit err_last, input int base);
        pkt_beat_t b;
        bit        done = 0;
        for (int i = 0; i < len; i++) begin
            b.sop  = (i == 0) || (i == stray_at);
            b.eop  = (i == len - 1);
            b.err  = (i == len - 1) && err_last;
            b.data = {ch[0], 15'(base + i)};
            src_q[ch].push_back(b);
            if (!done) begin
                if (i > 0 && b.sop) begin
                    exp_q[ch].push_back('{sop: 1'b0, eop: 1'b1, err: 1'b1, data: b.data});
                    done = 1;
                end else if (b.eop) begin
                    exp_q[ch].push_back('{sop: (i == 0), eop: 1'b1, err: b.err, data: b.data});
                    done = 1;
                end else if (i == MAX_LEN - 1) begin
                    exp_q[ch].push_back('{sop: (i == 0), eop: 1'b1, err: 1'b1, data: b.data});
                    done = 1;
                end else begin
                    exp_q[ch].push_back('{sop: (i == 0), eop: 1'b0, err: b.err, data: b.data});
                end
            end
        end
    endtask

    task automatic add_garbage(input int ch);
        pkt_beat_t b;
        b.sop  = 1'b0;
        b.eop  = 1'($urandom_range(1));
        b.err  = 1'($urandom_range(1));
        b.data = {ch[0], 15'h7F00};
        src_q[ch].push_back(b);
    endtask

    task automatic drive_ch(input int ch, input bit v, input pkt_beat_t b);
        if (ch == 0) begin
            ch0_vld = v; ch0_sop = b.sop; ch0_eop = b.eop; ch0_err = b.err; ch0_din = b.data;
        end else begin
            ch1_vld = v; ch1_sop = b.sop; ch1_eop = b.eop; ch1_err = b.err; ch1_din = b.data;
        end
    endtask

    task automatic drive();
        pkt_beat_t b;
        for (int ch = 0; ch < 2; ch++) begin
            if (src_q[ch].size() > 0 && $urandom_range(99) >= gap_pct) begin
                b = src_q[ch][0];
                drive_ch(ch, 1'b1, b);
                if (b.sop && first_present[ch] < 0) first_present[ch] = cyc;
            end else begin
                b = '0;
                b.sop = idle_sop[ch];
                drive_ch(ch, 1'b0, b);
            end
        end
        case (rdy_mode)
            1:       dout_rdy = ($urandom_range(99) < 70);
            2:       begin dout_rdy = pat[pat_idx % 4]; pat_idx++; end
            default: dout_rdy = 1'b1;
        endcase
    endtask

    task automatic sample();
        bit          a0, a1;
        int          ch;
        pkt_beat_t   e;
        logic [31:0] got;
        a0 = ch0_vld && ch0_rdy;
        a1 = ch1_vld && ch1_rdy;
        if (mirror_on) begin
            if (in_pkt0 || (a0 && ch0_sop)) chk("rdy_mirror", 32'(ch0_rdy), 32'(dout_rdy));
            chk("ch1_rdy_low", 32'(ch1_rdy), 32'd0);
        end
        if (a0 && ch0_sop) in_pkt0 = 1;
        if (a0 && ch0_eop) in_pkt0 = 0;
        if (a0) void'(src_q[0].pop_front());
        if (a1) void'(src_q[1].pop_front());
        if (dout_vld) begin
            ch  = int'(dout[DW-1]);
            got = 32'({dout_sop, dout_eop, dout_err, dout});
            if (exp_q[ch].size() == 0) begin
                chk("unexpected_beat", 32'(exp_q[ch].size()), 32'd1);
            end else begin
                e = exp_q[ch].pop_front();
                chk("beat", got, 32'(e));
            end
            if (cur_ch >= 0) chk("no_interleave", 32'(ch), 32'(cur_ch));
            if (dout_sop) begin
                cur_ch = ch;
                sop_order.push_back(ch);
                sop_cyc.push_back(cyc);
            end
            if (dout_eop) begin
                cur_ch = -1;
                eop_cyc.push_back(cyc);
            end
            out_cnt[ch]++;
        end
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_drain(input int max_cyc);
        int n = 0;
        while ((src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size()) > 0 && n < max_cyc) begin
            step();
            n++;
        end
        chk("drained", 32'(src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size()), 32'd0);
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic clear_logs();
        sop_order.delete();
        sop_cyc.delete();
        eop_cyc.delete();
        out_cnt[0] = 0;
        out_cnt[1] = 0;
        first_present[0] = -1;
        first_present[1] = -1;
    endtask

    task automatic do_reset(input bit check);
        rst = 1'b1;
        drive_ch(0, 1'b0, '0);
        drive_ch(1, 1'b0, '0);
        for (int ch = 0; ch < 2; ch++) begin
            src_q[ch].delete();
            exp_q[ch].delete();
        end
        cur_ch  = -1;
        in_pkt0 = 0;
        @(negedge clk);
        if (check) begin
            chk("rst_ch0_rdy", 32'(ch0_rdy), 32'd0);
            chk("rst_ch1_rdy", 32'(ch1_rdy), 32'd0);
        end
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
        @(negedge clk);
        if (check) begin
            chk("rst_dout_vld", 32'(dout_vld), 32'd0);
            chk("rst_dout_flags", 32'({dout_sop, dout_eop, dout_err}), 32'd0);
            chk("rst_dout", 32'(dout), 32'd0);
`ifdef PKT_ARB_STAT_EN
            chk("rst_pkt_cnt0", 32'(pkt_cnt0), 32'd0);
            chk("rst_pkt_cnt1", 32'(pkt_cnt1), 32'd0);
            chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, len, kind;
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        idle_sop[0] = 0;
        idle_sop[1] = 0;
        clear_logs();
        @(posedge clk);
        #1;
        do_reset(1);

        // Single 12-beat packet, data 1..12
        clear_logs();
        add_pkt(0, 12, -1, 0, 1);
        run_drain(200);
        chk("t1_beats", 32'(out_cnt[0]), 32'd12);
        if (sop_cyc.size() > 0 && eop_cyc.size() > 0) begin
            chk("t1_latency", 32'(sop_cyc[0] - first_present[0]), 32'd2);
            chk("t1_span", 32'(eop_cyc[0] - sop_cyc[0]), 32'd11);
        end else begin
            chk("t1_sop_eop_seen", 32'(sop_cyc.size() + eop_cyc.size()), 32'd2);
        end

        // Both channels always requesting: strict alternation with one bubble
        do_reset(0);
        clear_logs();
        for (int p = 0; p < 3; p++) begin
            add_pkt(0, 4, -1, 0, 100 + 10 * p);
            add_pkt(1, 4, -1, 0, 200 + 10 * p);
        end
        run_drain(300);
        chk("t2_pkts", 32'(sop_order.size()), 32'd6);
        for (int k = 0; k < sop_order.size() && k < 6; k++) chk("t2_order", 32'(sop_order[k]), 32'(k % 2));
        for (int k = 1; k < sop_cyc.size() && k <= eop_cyc.size(); k++)
            chk("t2_bubble", 32'(sop_cyc[k] - eop_cyc[k-1]), 32'd2);
`ifdef PKT_ARB_STAT_EN
        chk("t2_pkt_cnt0", 32'(pkt_cnt0), 32'd3);
        chk("t2_pkt_cnt1", 32'(pkt_cnt1), 32'd3);
        chk("t2_err_cnt", 32'(err_cnt), 32'd0);
`endif

        // Over-length packet on ch1, then a normal ch0 packet
        clear_logs();
        add_pkt(1, 200, -1, 0, 1000);
        run_drain(600);
        chk("t3_ch1_beats", 32'(out_cnt[1]), 32'(MAX_LEN));
        add_pkt(0, 5, -1, 1, 3000);
        run_drain(100);
        chk("t3_ch0_beats", 32'(out_cnt[0]), 32'd5);

        // Stray sop inside a ch0 packet, then a normal packet
        clear_logs();
        add_pkt(0, 6, 3, 0, 4000);
        run_drain(100);
        add_pkt(0, 3, -1, 0, 4100);
        run_drain(100);
        chk("t4_pkts", 32'(sop_order.size()), 32'd2);

        // Back-pressure pattern on dout_rdy; ch1 holds sop without vld
        clear_logs();
        rdy_mode    = 2;
        pat_idx     = 0;
        idle_sop[1] = 1;
        mirror_on   = 1;
        in_pkt0     = 0;
        add_pkt(0, 10, -1, 0, 5000);
        run_drain(200);
        chk("t5_beats", 32'(out_cnt[0]), 32'd10);
        mirror_on   = 0;
        idle_sop[1] = 0;

        // Randomized mixed traffic
        rdy_mode = 1;
        gap_pct  = 20;
        for (int it = 0; it < 40; it++) begin
            for (int ch = 0; ch < 2; ch++) begin
                kind = $urandom_range(99);
                if (kind < 80) begin
                    add_pkt(ch, $urandom_range(10, 1), -1, 1'($urandom_range(1)), 6000 + 200 * it);
                end else if (kind < 90) begin
                    len = $urandom_range(10, 3);
                    add_pkt(ch, len, $urandom_range(len - 2, 1), 0, 6000 + 200 * it);
                end else if (kind < 95) begin
                    add_pkt(ch, $urandom_range(140, 129), -1, 0, 6000 + 200 * it);
                end else begin
                    add_garbage(ch);
                    add_pkt(ch, $urandom_range(6, 2), -1, 0, 6000 + 200 * it);
                end
            end
        end
        run_drain(30000);
        rdy_mode = 0;
        gap_pct  = 0;

        // Reset in the middle of a packet, then tie goes to ch0
        clear_logs();
        add_pkt(0, 20, -1, 0, 7000);
        for (int i = 0; i < 8; i++) step();
        do_reset(1);
        clear_logs();
        add_pkt(1, 3, -1, 0, 7100);
        add_pkt(0, 3, -1, 0, 7200);
        run_drain(100);
        chk("t6_pkts", 32'(sop_order.size()), 32'd2);
        if (sop_order.size() > 0) chk("t6_first_grant", 32'(sop_order[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
